// File: rtl/noc_pkg.sv
// Shared definitions for the mesh NoC: port count and direction indices.
package noc_pkg;

   localparam int dirs_lp = 5;

   typedef enum logic [2:0] {
      P = 3'd0,
      W = 3'd1,
      E = 3'd2,
      N = 3'd3,
      S = 3'd4
   } dirs_e;

endpackage

// File: rtl/round_robin_arb.sv
// Round-robin arbiter: combinational grant, pointer advances past the
// granted requester only when the grant is consumed.
module round_robin_arb #(
   parameter int inputs_p = 5
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [inputs_p-1:0] reqs_i,
   output logic [inputs_p-1:0] grants_o,
   output logic                v_o,
   input  logic                yumi_i
);

   localparam int ptr_width_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1;

   typedef logic [ptr_width_lp:0] wide_t;

   logic [ptr_width_lp-1:0] ptr_r;
   logic [ptr_width_lp-1:0] grant_idx;
   logic                    found;
   wide_t                   cand;

   // Scan requesters starting at the pointer, wrapping modulo inputs_p.
   always_comb begin
      grants_o  = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < inputs_p; k++) begin
         cand = wide_t'(ptr_r) + wide_t'(k);
         if (cand >= wide_t'(inputs_p)) begin
            cand = cand - wide_t'(inputs_p);
         end
         if (!found && reqs_i[cand[ptr_width_lp-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[ptr_width_lp-1:0];
         end
      end
      if (found) begin
         grants_o[grant_idx] = 1'b1;
      end
   end

   assign v_o = found;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_r <= '0;
      end else if (yumi_i && found) begin
         ptr_r <= (grant_idx == ptr_width_lp'(inputs_p - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mesh_router.sv
// Combinational 5-port XY-routing mesh router; the only state is one
// round-robin arbiter per output port.
module mesh_router
   import noc_pkg::*;
#(
   parameter int width_p        = 8,
   parameter int x_cord_width_p = 2,
   parameter int y_cord_width_p = 2
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [dirs_lp-1:0][width_p-1:0]  data_i,
   input  logic [dirs_lp-1:0]               v_i,
   output logic [dirs_lp-1:0]               yumi_o,
   input  logic [dirs_lp-1:0]               ready_i,
   output logic [dirs_lp-1:0][width_p-1:0]  data_o,
   output logic [dirs_lp-1:0]               v_o,
   input  logic [x_cord_width_p-1:0]        my_x_i,
   input  logic [y_cord_width_p-1:0]        my_y_i
);

   dirs_e                           route [dirs_lp];
   logic [dirs_lp-1:0][dirs_lp-1:0] req;
   logic [dirs_lp-1:0][dirs_lp-1:0] grant;
   logic [dirs_lp-1:0]              arb_v;
   logic [dirs_lp-1:0]              xfer;

   // X is resolved fully before Y; a packet already at this tile goes to P.
   always_comb begin
      for (int i = 0; i < dirs_lp; i++) begin
         if (data_i[i][x_cord_width_p-1:0] < my_x_i) begin
            route[i] = W;
         end else if (data_i[i][x_cord_width_p-1:0] > my_x_i) begin
            route[i] = E;
         end else if (data_i[i][x_cord_width_p+y_cord_width_p-1:x_cord_width_p] < my_y_i) begin
            route[i] = N;
         end else if (data_i[i][x_cord_width_p+y_cord_width_p-1:x_cord_width_p] > my_y_i) begin
            route[i] = S;
         end else begin
            route[i] = P;
         end
      end
   end

   always_comb begin
      req = '0;
      for (int o = 0; o < dirs_lp; o++) begin
         for (int i = 0; i < dirs_lp; i++) begin
            req[o][i] = v_i[i] && (route[i] == dirs_e'(o));
         end
      end
   end

   for (genvar o = 0; o < dirs_lp; o++) begin : g_arb
      round_robin_arb #(
         .inputs_p (dirs_lp)
      ) arb (
         .clk_i    (clk_i),
         .reset_i  (reset_i),
         .reqs_i   (req[o]),
         .grants_o (grant[o]),
         .v_o      (arb_v[o]),
         .yumi_i   (xfer[o])
      );
   end

   // Reset hides all handshakes so packets wait upstream untouched.
   assign xfer = arb_v & ready_i & {dirs_lp{~reset_i}};
   assign v_o  = arb_v & {dirs_lp{~reset_i}};

   always_comb begin
      data_o = '0;
      yumi_o = '0;
      for (int o = 0; o < dirs_lp; o++) begin
         for (int i = 0; i < dirs_lp; i++) begin
            if (grant[o][i]) begin
               data_o[o] = data_i[i];
            end
            yumi_o[i] = yumi_o[i] | (grant[o][i] & xfer[o]);
         end
      end
   end

endmodule

// File: tb/tb_mesh_router.sv
// Self-checking bench for mesh_router: directed scenarios then random
// traffic, compared against a per-output round-robin reference model.
module tb_mesh_router;
   import noc_pkg::*;

   logic            clk_i = 1'b0;
   logic            reset_i;
   logic [4:0][7:0] data_i;
   logic [4:0][7:0] data_o;
   logic [4:0]      v_i;
   logic [4:0]      yumi_o;
   logic [4:0]      ready_i;
   logic [4:0]      v_o;
   logic [1:0]      my_x_i;
   logic [1:0]      my_y_i;

   int tests_run    = 0;
   int tests_failed = 0;
   int last_grant [5];
   int winner     [5];

   logic [4:0] contention_yumi [5];

   always #5 clk_i = ~clk_i;

   mesh_router #(
      .width_p        (8),
      .x_cord_width_p (2),
      .y_cord_width_p (2)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (data_i),
      .v_i     (v_i),
      .yumi_o  (yumi_o),
      .ready_i (ready_i),
      .data_o  (data_o),
      .v_o     (v_o),
      .my_x_i  (my_x_i),
      .my_y_i  (my_y_i)
   );

   function automatic int route_of(logic [7:0] d, int mx, int my);
      int dx = int'(d[1:0]);
      int dy = int'(d[3:2]);
      if (dx < mx) return 1;
      if (dx > mx) return 2;
      if (dy < my) return 3;
      if (dy > my) return 4;
      return 0;
   endfunction

   task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(int x, int y, logic rst, logic [4:0] v, logic [4:0] rdy, logic [39:0] d);
      my_x_i  = 2'(x);
      my_y_i  = 2'(y);
      reset_i = rst;
      v_i     = v;
      ready_i = rdy;
      data_i  = d;
   endtask

   // Model: each output serves the first routed requester after its last winner.
   task automatic check_output(string tag);
      logic [4:0] exp_v;
      logic [4:0] exp_yumi;
      int c;
      #1;
      exp_v    = '0;
      exp_yumi = '0;
      for (int o = 0; o < 5; o++) begin
         winner[o] = -1;
         for (int k = 1; k <= 5; k++) begin
            c = (last_grant[o] + k) % 5;
            if (winner[o] < 0 && v_i[c] && route_of(data_i[c], int'(my_x_i), int'(my_y_i)) == o) begin
               winner[o] = c;
            end
         end
         if (winner[o] >= 0 && !reset_i) begin
            exp_v[o] = 1'b1;
            if (ready_i[o]) exp_yumi[winner[o]] = 1'b1;
         end
      end
      check({tag, ".v_o"}, 64'(v_o), 64'(exp_v));
      check({tag, ".yumi_o"}, 64'(yumi_o), 64'(exp_yumi));
      if (!reset_i) begin
         for (int o = 0; o < 5; o++) begin
            check($sformatf("%s.data_o[%0d]", tag, o), 64'(data_o[o]),
                  (winner[o] >= 0) ? 64'(data_i[winner[o]]) : 64'd0);
         end
      end
   endtask

   task automatic advance();
      for (int o = 0; o < 5; o++) begin
         if (reset_i) last_grant[o] = 4;
         else if (winner[o] >= 0 && ready_i[o]) last_grant[o] = winner[o];
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      for (int o = 0; o < 5; o++) begin
         last_grant[o] = 4;
         winner[o]     = -1;
      end
      contention_yumi[0] = 5'b00001;
      contention_yumi[1] = 5'b00100;
      contention_yumi[2] = 5'b01000;
      contention_yumi[3] = 5'b10000;
      contention_yumi[4] = 5'b00001;

      apply_stimulus(0, 0, 1'b1, 5'b00000, 5'b00000, 40'h0);
      @(negedge clk_i);
      check_output("reset_idle");
      advance();
      apply_stimulus(1, 1, 1'b1, 5'b11111, 5'b11111, 40'({$urandom(), $urandom()}));
      check_output("reset_busy");
      check("reset_busy.quiet", 64'({v_o, yumi_o}), 64'd0);
      advance();

      apply_stimulus(1, 2, 1'b0, 5'b00001, 5'b11111, 40'h00_00_00_00_09);
      check_output("local");
      check("local.v_p", 64'(v_o[P]), 64'd1);
      check("local.data_p", 64'(data_o[P]), 64'h09);
      check("local.yumi_p", 64'(yumi_o[P]), 64'd1);
      advance();

      apply_stimulus(1, 1, 1'b0, 5'b00001, 5'b11111, 40'h00_00_00_00_03);
      check_output("xy_x_first");
      check("xy_x_first.only_e", 64'(v_o), 64'b00100);
      advance();
      apply_stimulus(1, 1, 1'b0, 5'b01000, 5'b11111, 40'h00_0D_00_00_00);
      check_output("xy_n_to_s");
      check("xy_n_to_s.only_s", 64'(v_o), 64'b10000);
      advance();

      apply_stimulus(0, 0, 1'b1, 5'b00000, 5'b00000, 40'h0);
      check_output("pre_contention_reset");
      advance();
      for (int t = 0; t < 5; t++) begin
         apply_stimulus(0, 0, 1'b0, 5'b11101, 5'b00001, 40'h40_30_20_00_10);
         check_output($sformatf("contention%0d", t));
         check($sformatf("contention%0d.order", t), 64'(yumi_o), 64'(contention_yumi[t]));
         advance();
      end

      for (int t = 0; t < 3; t++) begin
         apply_stimulus(0, 0, 1'b0, 5'b00010, 5'b00000, 40'h00_00_00_32_00);
         check_output($sformatf("backpressure%0d", t));
         check($sformatf("backpressure%0d.v_e", t), 64'(v_o), 64'b00100);
         check($sformatf("backpressure%0d.yumi", t), 64'(yumi_o), 64'd0);
         check($sformatf("backpressure%0d.data_e", t), 64'(data_o[E]), 64'h32);
         advance();
      end
      apply_stimulus(0, 0, 1'b0, 5'b00010, 5'b00100, 40'h00_00_00_32_00);
      check_output("backpressure_release");
      check("backpressure_release.yumi_w", 64'(yumi_o), 64'b00010);
      advance();

      apply_stimulus(1, 1, 1'b0, 5'b00011, 5'b11111, 40'h00_00_00_05_06);
      check_output("concurrent");
      check("concurrent.yumi", 64'(yumi_o), 64'b00011);
      advance();

      for (int t = 0; t < 2; t++) begin
         apply_stimulus(0, 0, 1'b0, 5'b11101, 5'b00001, 40'h40_30_20_00_10);
         check_output($sformatf("midtraffic%0d", t));
         advance();
      end
      apply_stimulus(0, 0, 1'b1, 5'b11101, 5'b00001, 40'h40_30_20_00_10);
      check_output("midreset");
      check("midreset.quiet", 64'({v_o, yumi_o}), 64'd0);
      advance();
      apply_stimulus(0, 0, 1'b0, 5'b11101, 5'b00001, 40'h40_30_20_00_10);
      check_output("after_reset");
      check("after_reset.p_first", 64'(yumi_o), 64'b00001);
      advance();

      for (int t = 0; t < 400; t++) begin
         apply_stimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        ($urandom_range(0, 31) == 0), 5'($urandom), 5'($urandom),
                        40'({$urandom(), $urandom()}));
         check_output($sformatf("random%0d", t));
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mesh_router.md
Name: mesh_router

Overview:
- Combinational 5-port dimension-ordered (X-then-Y) router for a 2-D mesh NoC tile.
- Ports: P (local processor), W, E, N, S.
- Each input presents the head of an upstream FIFO (valid/yumi). Each output drives a downstream FIFO input (valid/ready).
- No internal packet buffering. The only state is one round-robin arbiter per output.

Parameters:
- dirs_lp, 5, number of ports; fixed at 5. Index order comes from the shared package: P=0, W=1, E=2, N=3, S=4.
- width_p, 8, packet width in bits, including the embedded destination coordinates.
- x_cord_width_p, 2, width of the X coordinate field.
- y_cord_width_p, 2, width of the Y coordinate field.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- data_i  in  [dirs_lp][width_p]  packet at the head of each input.
- v_i  in  [dirs_lp]  input packet valid.
- yumi_o  out  [dirs_lp]  input packet consumed this cycle.
- ready_i  in  [dirs_lp]  downstream can accept on each output.
- data_o  out  [dirs_lp][width_p]  routed packet per output.
- v_o  out  [dirs_lp]  output packet valid.
- my_x_i  in  x_cord_width_p  this tile's X coordinate.
- my_y_i  in  y_cord_width_p  this tile's Y coordinate.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, reset_i).
- Packet fields:
  - dest_x = data[x_cord_width_p-1:0].
  - dest_y = data[x_cord_width_p+y_cord_width_p-1:x_cord_width_p].
  - Upper bits are payload. The router passes every bit through unmodified.
- Route decision per valid input, XY order, unsigned compares:
  - dest_x < my_x -> W.
  - dest_x > my_x -> E.
  - Otherwise, dest_y < my_y -> N (N is toward y-1).
  - dest_y > my_y -> S.
  - Otherwise -> P.
- Request matrix: req[out][in] = v_i[in] & (route(in) == out).
  - A packet never returns on the port it arrived on.
  - Requests are not masked by turn legality.
- Arbitration: each output has an independent round-robin arbiter over the 5 inputs.
  - Grant is combinational in the current cycle.
  - Priority starts from the input after the last input granted with a transfer.
  - Reset priority: input 0 (P) highest, then W, E, N, S.
  - The pointer updates only when v_o[out] & ready_i[out]. Without a transfer the same grant is held.
- Outputs:
  - v_o[out] = any req[out][*]; independent of ready_i.
  - data_o[out] = data_i[granted input]. When v_o=0 it is don't-care; drive 0.
  - yumi_o[in] = input in is granted by its routed output AND ready_i of that output is 1.
  - yumi_o therefore implies the downstream accepts in the same cycle. Zero-cycle latency, input to output.
- Each input is granted by at most one output, because it routes to exactly one output.
- Simultaneous requests to different outputs all proceed in the same cycle; full crossbar concurrency.
- Reset:
  - While reset_i=1, v_o=0 and yumi_o=0 for all ports.
  - All arbiter pointers reset to their start state.
  - Reset mid-operation drops nothing. Packets remain in the upstream FIFOs and are re-arbitrated after reset.
- Unused edge ports: the tie-off is v_i=0 and ready_i=0. The router then never asserts yumi on that port. v_o may assert, but no transfer occurs.
- Fairness: under sustained contention, every requesting input is served within 5 transfers on that output.
- Back-pressure: ready_i=0 freezes the grant and deasserts yumi_o for that output only.

Decomposition:
- Shared package noc_pkg contains:
  - Direction enum Dirs {P=0, W=1, E=2, N=3, S=4}.
  - Constant dirs_lp=5.
- One sub-module, round_robin_arb:
  - Parameter inputs_p.
  - Ports: clk_i, reset_i, reqs_i, grants_o, v_o, yumi_i.
  - yumi_i advances the pointer.
  - The router instantiates it 5 times, once per output.

Test Plan:
- Local delivery, tile (1,2), width 8: P input data 8'b0000_10_01 (y=2, x=1), ready_i[P]=1 -> same cycle v_o[P]=1, data_o[P]=8'h09, yumi_o[P]=1.
- XY order, tile (1,1): input P dest (3,0) -> v_o[E]=1 only, even though Y also differs. Input N dest (1,3) -> v_o[S]=1.
- Contention, tile (0,0): P, N, S, E all valid for dest (0,0), ready_i[P]=1 held -> grants in order P, E, N, S, P. Exactly one yumi_o per cycle.
- Back-pressure: W input routed E with ready_i[E]=0 for 3 cycles -> v_o[E]=1, yumi_o[W]=0, data_o stable. Raising ready -> yumi_o[W]=1 that cycle.
- Concurrency and reset:
  - P->E and W->P in the same cycle -> both yumi asserted.
  - reset_i=1 mid-traffic -> v_o=0 and yumi_o=0. The next grant follows reset priority.
- 4x4 mesh of routers with FIFOs: each tile sends 16 packets (dest = own index XOR 0..15) -> every tile receives 16 unique packets, all with a matching dest field.
